aes128_key_sched_ctrl: RTL

Sequencer for AES-128 key expansion. It accepts a 128-bit cipher key with a start pulse and iterates one combinational round-key step once per clock for rounds 1..10. All 11 round keys (slot 0 = cipher key) go into an internal register file. The cipher datapath then reads round keys by index. It sits between key-load logic and the round datapath, so round-key generation happens once per key instead of per block.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes128_key_step.sv | 31 +++
 rtl/aes128_key_sched_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, the S-box, the round-constant table and the key-schedule FSM encoding.
package aes_pkg;

    localparam int NR = 10;
    localparam int KW = 128;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StFin
    } state_e;

    // S-box, byte 0x00 in the top 8 bits down to byte 0xff in the bottom 8 bits.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTable[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    // Round constant for rounds 1..NR; anything else yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-expansion round: previous round key and round number in, next round key out.
module aes128_key_step
    import aes_pkg::*;
(
    input  logic [KW-1:0] cur_key,
    input  logic [3:0]    rnd,
    output logic [KW-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;

    // Word 0 is the most significant word of the key.
    assign w0 = cur_key[127:96];
    assign w1 = cur_key[95:64];
    assign w2 = cur_key[63:32];
    assign w3 = cur_key[31:0];

    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign t   = sub ^ {rcon(rnd), 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: expands one cipher key into an 11-entry round-key table.
module aes128_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  logic [3:0]    rd_idx,
    output logic [KW-1:0] rd_key
);

    state_e        state_q, state_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [KW-1:0] cur_key_q, cur_key_d;
    logic          keys_valid_q, keys_valid_d;
    logic [KW-1:0] step_key;

    logic          slot_we;
    logic [3:0]    slot_widx;
    logic [KW-1:0] slot_wdata;
    logic [KW-1:0] slot_q [NR+1];
    logic [KW-1:0] rd_key_q;

    aes128_key_step u_step (
        .cur_key  (cur_key_q),
        .rnd      (rnd_q),
        .next_key (step_key)
    );

    // Next-state, table write control and status outputs.
    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        cur_key_d    = cur_key_q;
        keys_valid_d = keys_valid_q;
        slot_we      = 1'b0;
        slot_widx    = rnd_q;
        slot_wdata   = step_key;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            StIdle, StFin: begin
                done = (state_q == StFin);
                if (start) begin
                    // Accept a new key: slot 0 holds the cipher key itself.
                    slot_we      = 1'b1;
                    slot_widx    = 4'd0;
                    slot_wdata   = key;
                    cur_key_d    = key;
                    rnd_d        = 4'd1;
                    keys_valid_d = 1'b0;
                    state_d      = StExpand;
                end else begin
                    state_d = StIdle;
                end
            end
            StExpand: begin
                busy      = 1'b1;
                slot_we   = 1'b1;
                cur_key_d = step_key;
                if (rnd_q == 4'(NR)) begin
                    rnd_d        = 4'd0;
                    keys_valid_d = 1'b1;
                    state_d      = StFin;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rnd_q        <= 4'd0;
            keys_valid_q <= 1'b0;
            cur_key_q    <= '0;
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            keys_valid_q <= keys_valid_d;
            cur_key_q    <= cur_key_d;
        end
    end

    // Round-key table; contents survive reset and are only meaningful while keys_valid is set.
    always_ff @(posedge clk) begin
        if (slot_we && !rst) begin
            slot_q[slot_widx] <= slot_wdata;
        end
    end

    // Registered read port, no write bypass; out-of-range indices read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key_q <= '0;
        end else if (rd_idx <= 4'(NR)) begin
            rd_key_q <= slot_q[rd_idx];
        end else begin
            rd_key_q <= '0;
        end
    end

    assign keys_valid = keys_valid_q;
    assign rd_key     = rd_key_q;

endmodule
